// File: rtl/dcache_data_write_sink_if.sv
// Arbitrated data-array write request channel (ready/valid) into the write sink.
interface dcache_data_write_sink_if;
    logic        valid;
    logic        ready;
    logic [3:0]  way_en;
    logic [11:0] addr;
    logic        wmask;
    logic [63:0] data;
    logic        chosen;

    modport master (
        output valid, way_en, addr, wmask, data, chosen,
        input  ready
    );

    modport slave (
        input  valid, way_en, addr, wmask, data, chosen,
        output ready
    );
endinterface

// File: rtl/dcache_data_write_sink.sv
// 2-entry write buffer between the data-array write arbiter and the per-way SRAM write port.
// Optional per-byte even parity on the SRAM data is enabled by defining DATA_WRITE_PARITY_EN.
module dcache_data_write_sink (
    input  logic                         clock,
    input  logic                         reset,
    dcache_data_write_sink_if.slave      io_in,
    input  logic                         io_sram_stall,
    output logic [3:0]                   io_sram_en,
    output logic [8:0]                   io_sram_row,
    output logic [63:0]                  io_sram_data,
    output logic [7:0]                   io_sram_parity,
    output logic                         io_ack_0,
    output logic                         io_ack_1,
    output logic                         io_busy
);

    logic [3:0]  way_q    [2];
    logic [8:0]  row_q    [2];
    logic        wmask_q  [2];
    logic [63:0] data_q   [2];
    logic        chosen_q [2];

    logic [1:0]  count_q,     count_d;
    logic        enq_ptr_q,   enq_ptr_d;
    logic        deq_ptr_q,   deq_ptr_d;
    logic        ack_valid_q, ack_valid_d;
    logic        ack_id_q,    ack_id_d;

    logic        enq_s;
    logic        issue_s;
    logic        unused_addr_s;

    // Byte offset bits never reach the SRAM; only the row is kept.
    assign unused_addr_s = ^io_in.addr[2:0];

    assign io_in.ready = (count_q != 2'd2);
    assign enq_s       = io_in.valid & io_in.ready;
    assign issue_s     = (count_q != 2'd0) & ~io_sram_stall;

    assign io_sram_row  = row_q[deq_ptr_q];
    assign io_sram_data = data_q[deq_ptr_q];
    assign io_sram_en   = issue_s ? (way_q[deq_ptr_q] & {4{wmask_q[deq_ptr_q]}}) : 4'b0000;
    assign io_ack_0     = ack_valid_q & ~ack_id_q;
    assign io_ack_1     = ack_valid_q & ack_id_q;
    assign io_busy      = (count_q != 2'd0);

`ifdef DATA_WRITE_PARITY_EN
    function automatic logic [7:0] byte_even_parity(input logic [63:0] d);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction

    assign io_sram_parity = byte_even_parity(io_sram_data);
`else
    assign io_sram_parity = 8'h00;
`endif

    // Next-state for occupancy, pointers and the completion pulse.
    always_comb begin
        count_d     = count_q;
        enq_ptr_d   = enq_ptr_q;
        deq_ptr_d   = deq_ptr_q;
        ack_valid_d = issue_s;
        ack_id_d    = ack_id_q;
        if (enq_s && !issue_s) begin
            count_d = count_q + 2'd1;
        end else if (!enq_s && issue_s) begin
            count_d = count_q - 2'd1;
        end else begin
            count_d = count_q;
        end
        if (enq_s) begin
            enq_ptr_d = ~enq_ptr_q;
        end else begin
            enq_ptr_d = enq_ptr_q;
        end
        if (issue_s) begin
            deq_ptr_d = ~deq_ptr_q;
            ack_id_d  = chosen_q[deq_ptr_q];
        end else begin
            deq_ptr_d = deq_ptr_q;
            ack_id_d  = ack_id_q;
        end
    end

    // Control state; reset drops buffered writes and any pending ack.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q     <= 2'd0;
            enq_ptr_q   <= 1'b0;
            deq_ptr_q   <= 1'b0;
            ack_valid_q <= 1'b0;
            ack_id_q    <= 1'b0;
        end else begin
            count_q     <= count_d;
            enq_ptr_q   <= enq_ptr_d;
            deq_ptr_q   <= deq_ptr_d;
            ack_valid_q <= ack_valid_d;
            ack_id_q    <= ack_id_d;
        end
    end

    // Entry payload storage, written at the enqueue pointer.
    always_ff @(posedge clock) begin
        if (enq_s) begin
            way_q[enq_ptr_q]    <= io_in.way_en;
            row_q[enq_ptr_q]    <= io_in.addr[11:3];
            wmask_q[enq_ptr_q]  <= io_in.wmask;
            data_q[enq_ptr_q]   <= io_in.data;
            chosen_q[enq_ptr_q] <= io_in.chosen;
        end
    end

endmodule

// File: tb/tb_dcache_data_write_sink.sv
// Directed, table-driven bench for dcache_data_write_sink (one table row per clock cycle).
module tb_dcache_data_write_sink;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_sram_stall;
    logic [3:0]  io_sram_en;
    logic [8:0]  io_sram_row;
    logic [63:0] io_sram_data;
    logic [7:0]  io_sram_parity;
    logic        io_ack_0;
    logic        io_ack_1;
    logic        io_busy;

    int tests_run = 0;
    int tests_failed = 0;

    dcache_data_write_sink_if in_if ();

    dcache_data_write_sink dut (
        .clock          (clock),
        .reset          (reset),
        .io_in          (in_if.slave),
        .io_sram_stall  (io_sram_stall),
        .io_sram_en     (io_sram_en),
        .io_sram_row    (io_sram_row),
        .io_sram_data   (io_sram_data),
        .io_sram_parity (io_sram_parity),
        .io_ack_0       (io_ack_0),
        .io_ack_1       (io_ack_1),
        .io_busy        (io_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [3:0]  way;
        logic [11:0] addr;
        logic        wm;
        logic [63:0] data;
        logic        ch;
        logic        stall;
        logic        e_ready;
        logic [3:0]  e_en;
        logic        e_ack0;
        logic        e_ack1;
        logic        e_busy;
        logic        chk_head;
        logic [8:0]  e_row;
        logic [63:0] e_data;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic v, logic [3:0] way, logic [11:0] addr, logic wm,
                                logic [63:0] data, logic ch, logic stall, logic e_ready,
                                logic [3:0] e_en, logic e_ack0, logic e_ack1, logic e_busy,
                                logic chk_head, logic [8:0] e_row, logic [63:0] e_data);
        vec_t r;
        r.v = v; r.way = way; r.addr = addr; r.wm = wm; r.data = data; r.ch = ch;
        r.stall = stall; r.e_ready = e_ready; r.e_en = e_en; r.e_ack0 = e_ack0;
        r.e_ack1 = e_ack1; r.e_busy = e_busy; r.chk_head = chk_head; r.e_row = e_row;
        r.e_data = e_data;
        return r;
    endfunction

    function automatic logic [7:0] exp_parity(input logic [63:0] d);
        logic [7:0] p;
        p = 8'h00;
`ifdef DATA_WRITE_PARITY_EN
        for (int i = 0; i < 8; i++) begin
            p[i] = ^d[8*i +: 8];
        end
`endif
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] way, input logic [11:0] addr,
                         input logic wm, input logic [63:0] data, input logic ch, input logic stall);
        in_if.valid   = v;
        in_if.way_en  = way;
        in_if.addr    = addr;
        in_if.wmask   = wm;
        in_if.data    = data;
        in_if.chosen  = ch;
        io_sram_stall = stall;
    endtask

    task automatic idle_next();
        drive(1'b0, 4'b0000, 12'h000, 1'b0, 64'h0, 1'b0, 1'b0);
        @(posedge clock); #1;
    endtask

    localparam logic [63:0] D1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] D2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] D3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] DP = 64'h0100_0000_0000_00FF;

    initial begin
        // Single write, accepted in the first table cycle.
        vq.push_back(mk(1'b1, 4'b0100, 12'h1F8, 1'b1, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 64'h0));
        vq.push_back(mk(1'b0, 4'b0000, 12'h000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 9'h03F, 64'hDEAD_BEEF_0123_4567));
        vq.push_back(mk(1'b0, 4'b0000, 12'h000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 64'h0));
        vq.push_back(mk(1'b0, 4'b0000, 12'h000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 64'h0));
        // Stalled back-to-back: fill to 2, third held off, then drain in order.
        vq.push_back(mk(1'b1, 4'b0001, 12'h008, 1'b1, D1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 64'h0));
        vq.push_back(mk(1'b1, 4'b0010, 12'h010, 1'b1, D2, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 9'h001, D1));
        vq.push_back(mk(1'b1, 4'b1000, 12'h018, 1'b1, D3, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 9'h001, D1));
        vq.push_back(mk(1'b1, 4'b1000, 12'h018, 1'b1, D3, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 9'h001, D1));
        vq.push_back(mk(1'b1, 4'b1000, 12'h018, 1'b1, D3, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 9'h001, D1));
        vq.push_back(mk(1'b1, 4'b1000, 12'h018, 1'b1, D3, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 9'h002, D2));
        vq.push_back(mk(1'b0, 4'b0000, 12'h000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b1, 9'h003, D3));
        vq.push_back(mk(1'b0, 4'b0000, 12'h000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 64'h0));
        vq.push_back(mk(1'b0, 4'b0000, 12'h000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 64'h0));
        // No-op write (wmask=0): dequeues and acks with no enable.
        vq.push_back(mk(1'b1, 4'b0001, 12'h020, 1'b0, 64'h5555, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 64'h0));
        vq.push_back(mk(1'b0, 4'b0000, 12'h000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 9'h004, 64'h5555));
        vq.push_back(mk(1'b0, 4'b0000, 12'h000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 64'h0));
        // Alternating requesters, one per cycle, no stall.
        vq.push_back(mk(1'b1, 4'b0001, 12'h100, 1'b1, 64'hA0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 64'h0));
        vq.push_back(mk(1'b1, 4'b0010, 12'h108, 1'b1, 64'hA1, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 9'h020, 64'hA0));
        vq.push_back(mk(1'b1, 4'b0100, 12'h110, 1'b1, 64'hA2, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 9'h021, 64'hA1));
        vq.push_back(mk(1'b1, 4'b1000, 12'h118, 1'b1, 64'hA3, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b1, 1'b1, 1'b1, 9'h022, 64'hA2));
        vq.push_back(mk(1'b0, 4'b0000, 12'h000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b1, 9'h023, 64'hA3));
        vq.push_back(mk(1'b0, 4'b0000, 12'h000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 64'h0));
        vq.push_back(mk(1'b0, 4'b0000, 12'h000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 64'h0));
        // Parity pattern on the head data.
        vq.push_back(mk(1'b1, 4'b0001, 12'h000, 1'b1, DP, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 64'h0));
        vq.push_back(mk(1'b0, 4'b0000, 12'h000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 9'h000, DP));
        vq.push_back(mk(1'b0, 4'b0000, 12'h000, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 64'h0));

        reset = 1'b1;
        drive(1'b0, 4'b0000, 12'h000, 1'b0, 64'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_ready", {63'd0, in_if.ready}, 64'd1);
        check("rst_en",    {60'd0, io_sram_en},  64'd0);
        check("rst_ack0",  {63'd0, io_ack_0},    64'd0);
        check("rst_ack1",  {63'd0, io_ack_1},    64'd0);
        check("rst_busy",  {63'd0, io_busy},     64'd0);
        @(posedge clock); #1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].v, vq[i].way, vq[i].addr, vq[i].wm, vq[i].data, vq[i].ch, vq[i].stall);
            @(negedge clock);
            check($sformatf("v%0d_ready", i), {63'd0, in_if.ready}, {63'd0, vq[i].e_ready});
            check($sformatf("v%0d_en", i),    {60'd0, io_sram_en},  {60'd0, vq[i].e_en});
            check($sformatf("v%0d_ack0", i),  {63'd0, io_ack_0},    {63'd0, vq[i].e_ack0});
            check($sformatf("v%0d_ack1", i),  {63'd0, io_ack_1},    {63'd0, vq[i].e_ack1});
            check($sformatf("v%0d_busy", i),  {63'd0, io_busy},     {63'd0, vq[i].e_busy});
            if (vq[i].chk_head) begin
                check($sformatf("v%0d_row", i),    {55'd0, io_sram_row}, {55'd0, vq[i].e_row});
                check($sformatf("v%0d_data", i),   io_sram_data,         vq[i].e_data);
                check($sformatf("v%0d_parity", i), {56'd0, io_sram_parity}, {56'd0, exp_parity(vq[i].e_data)});
            end
            @(posedge clock); #1;
        end

        // Fixed parity expectation for the 0100..00FF pattern, head still holding it.
        drive(1'b1, 4'b0001, 12'h000, 1'b1, DP, 1'b0, 1'b1);
        @(posedge clock); #1;
        @(negedge clock);
`ifdef DATA_WRITE_PARITY_EN
        check("parity_const", {56'd0, io_sram_parity}, {56'd0, 8'b1000_0000});
`else
        check("parity_const", {56'd0, io_sram_parity}, 64'd0);
`endif
        @(posedge clock); #1;

        // Fill to 2 under stall, then reset: both entries dropped, no ack ever.
        drive(1'b1, 4'b0010, 12'h040, 1'b1, D2, 1'b1, 1'b1);
        @(negedge clock);
        check("full_ready", {63'd0, in_if.ready}, 64'd0);
        check("full_busy",  {63'd0, io_busy},     64'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        drive(1'b0, 4'b0000, 12'h000, 1'b0, 64'h0, 1'b0, 1'b0);
        @(negedge clock);
        check("rst2_ready", {63'd0, in_if.ready}, 64'd1);
        check("rst2_busy",  {63'd0, io_busy},     64'd0);
        check("rst2_en",    {60'd0, io_sram_en},  64'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst2_noack_%0d", k), {62'd0, io_ack_1, io_ack_0}, 64'd0);
            @(posedge clock); #1;
            @(negedge clock);
        end
        @(posedge clock); #1;

        // In-flight ack is killed when reset is sampled on the issue edge.
        drive(1'b1, 4'b0100, 12'h080, 1'b1, D3, 1'b1, 1'b0);
        @(posedge clock); #1;
        drive(1'b0, 4'b0000, 12'h000, 1'b0, 64'h0, 1'b0, 1'b0);
        @(negedge clock);
        check("kill_en", {60'd0, io_sram_en}, {60'd0, 4'b0100});
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("kill_ack1", {63'd0, io_ack_1}, 64'd0);
        check("kill_busy", {63'd0, io_busy},  64'd0);
        idle_next();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
